muldiv_unit: RTL and testbench

Sequential multiply/divide unit for the MIPS datapath. It owns the HI/LO result registers and executes unsigned MULTU and DIVU as multi-cycle operations. It exposes a busy/stall handshake so the control unit can freeze the pipeline when an MFHI/MFLO read arrives while an operation is still in flight. It sits beside the ALU and takes its operands from regfile read ports rd1/rd2.

---
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_muldiv_unit.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Sequential unsigned multiply/divide unit owning the HI/LO registers.
// MULTU takes one cycle; DIVU runs a restoring shift-subtract loop.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  hilo_rd,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  busy,
  output logic                  done,
  output logic                  stall,
  output logic                  div_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_COMMIT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W:0]    rem_q, rem_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic          done_q, done_d;
  logic          dz_q, dz_d;

  logic          accept;
  logic [2*W-1:0] prod;
  logic [W+1:0]  shift_rem;
  logic [W+1:0]  diff;
  logic          borrow;

  assign accept = start & (state_q == S_IDLE) & ~op[1];

  assign prod = (2*W)'(a_q) * (2*W)'(b_q);

  // Extra top bit makes the borrow of the trial subtraction explicit.
  assign shift_rem = {rem_q, quo_q[W-1]};
  assign diff      = shift_rem - {2'b00, b_q};
  assign borrow    = diff[W+1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d   = a;
          b_d   = b;
          quo_d = a;
          rem_d = '0;
          cnt_d = '0;
          dz_d  = 1'b0;
          if (!op[0])
            state_d = S_MUL;
          else if (b == '0)
            state_d = S_COMMIT;
          else
            state_d = S_DIV;
        end
      end
      S_MUL: begin
        hi_d    = prod[2*W-1:W];
        lo_d    = prod[W-1:0];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_DIV: begin
        rem_d = borrow ? shift_rem[W:0] : diff[W:0];
        quo_d = {quo_q[W-2:0], ~borrow};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST)
          state_d = S_COMMIT;
      end
      S_COMMIT: begin
        if (b_q == '0) begin
          hi_d = a_q;
          lo_d = '1;
          dz_d = 1'b1;
        end else begin
          hi_d = rem_q[W-1:0];
          lo_d = quo_q;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign stall    = hilo_rd & busy;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hilo_rd;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;
  logic        div_zero;

  int total;
  int bad;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hilo_rd  (hilo_rd),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .stall    (stall),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;
    hilo_rd = 1'b0;
    tick();
    tick();
    total++;
    if ({hi, lo} !== 64'h0) begin
      bad++;
      $display("FAIL reset_hilo: got %h_%h want 0", hi, lo);
    end
    total++;
    if ({busy, done, div_zero, stall} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000",
               {busy, done, div_zero, stall});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_multu_max();
    start = 1'b1;
    op = 2'b00;
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    a = 32'h1234_5678;
    b = 32'h0;
    total++;
    if ({busy, done} !== 2'b10 || {hi, lo} !== 64'h0) begin
      bad++;
      $display("FAIL mul_e0: busy/done %b hilo %h_%h want 10 0_0",
               {busy, done}, hi, lo);
    end
    tick();
    total++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      bad++;
      $display("FAIL mul_result: got %h_%h want fffffffe_00000001",
               hi, lo);
    end
    total++;
    if ({busy, done} !== 2'b01) begin
      bad++;
      $display("FAIL mul_e1_flags: got %b want 01", {busy, done});
    end
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL mul_done_width: got %b want 0", done);
    end
  endtask

  task automatic test_divu();
    int n;
    start = 1'b1;
    op = 2'b01;
    a = 32'd100;
    b = 32'd7;
    tick();
    start = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'd3;
    n = 0;
    while (busy && n < 50) begin
      n++;
      if (n == 20) begin
        total++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h1 || done !== 1'b0) begin
          bad++;
          $display("FAIL div_hold: got %h_%h done %b want fffffffe_1 0",
                   hi, lo, done);
        end
      end
      tick();
    end
    total++;
    if (n !== 33) begin
      bad++;
      $display("FAIL div_busy_len: got %0d want 33", n);
    end
    total++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      bad++;
      $display("FAIL div_result: got hi=%0d lo=%0d want hi=2 lo=14",
               hi, lo);
    end
    total++;
    if ({done, div_zero} !== 2'b10) begin
      bad++;
      $display("FAIL div_flags: got %b want 10", {done, div_zero});
    end
    tick();
  endtask

  task automatic test_div_zero_back_to_back();
    start = 1'b1;
    op = 2'b01;
    a = 32'd5;
    b = 32'd0;
    tick();
    start = 1'b0;
    total++;
    if ({busy, div_zero} !== 2'b10) begin
      bad++;
      $display("FAIL dz_e0: got %b want 10", {busy, div_zero});
    end
    tick();
    total++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'd5) begin
      bad++;
      $display("FAIL dz_result: got %h_%h want 00000005_ffffffff",
               hi, lo);
    end
    total++;
    if ({busy, done, div_zero} !== 3'b011) begin
      bad++;
      $display("FAIL dz_flags: got %b want 011",
               {busy, done, div_zero});
    end
    start = 1'b1;
    op = 2'b00;
    a = 32'd3;
    b = 32'd4;
    tick();
    start = 1'b0;
    total++;
    if ({busy, done, div_zero} !== 3'b100 || lo !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL b2b_accept: flags %b lo %h want 100 ffffffff",
               {busy, done, div_zero}, lo);
    end
    tick();
    total++;
    if (hi !== 32'd0 || lo !== 32'd12 || done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_mul: got %h_%h done %b want 0_c 1",
               hi, lo, done);
    end
    tick();
  endtask

  task automatic test_stall();
    start = 1'b1;
    op = 2'b01;
    a = 32'hFFFF_FFFF;
    b = 32'h10;
    hilo_rd = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL stall_idle: got %b want 0", stall);
    end
    tick();
    start = 1'b0;
    for (int i = 0; i < 33; i++) begin
      total++;
      if (stall !== 1'b1) begin
        bad++;
        $display("FAIL stall_busy: edge E%0d got %b want 1", i, stall);
      end
      if (i == 20) begin
        total++;
        if (hi !== 32'd0 || lo !== 32'd12) begin
          bad++;
          $display("FAIL stall_hold: got %h_%h want 0_c", hi, lo);
        end
      end
      if (i == 9) begin
        start = 1'b1;
        op = 2'b00;
        a = 32'd2;
        b = 32'd3;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    total++;
    if (stall !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL stall_drop: stall/busy %b want 00", {stall, busy});
    end
    total++;
    if (lo !== 32'h0FFF_FFFF || hi !== 32'hF || done !== 1'b1) begin
      bad++;
      $display("FAIL stall_result: got %h_%h done %b want f_0fffffff 1",
               hi, lo, done);
    end
    hilo_rd = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_div();
    start = 1'b1;
    op = 2'b01;
    a = 32'd100;
    b = 32'd7;
    tick();
    start = 1'b0;
    for (int i = 1; i < 15; i++) tick();
    rst = 1'b1;
    #1;
    total++;
    if ({hi, lo} !== 64'h0 || {busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL rst_mid: got %h_%h flags %b want 0_0 00",
               hi, lo, {busy, done});
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL rst_no_done: cycle %0d flags %b want 00",
                 i, {busy, done});
        break;
      end
      tick();
    end
    start = 1'b1;
    op = 2'b00;
    a = 32'd6;
    b = 32'd7;
    tick();
    start = 1'b0;
    tick();
    total++;
    if (lo !== 32'd42 || hi !== 32'd0) begin
      bad++;
      $display("FAIL rst_then_mul: got %h_%h want 0_2a", hi, lo);
    end
    tick();
  endtask

  task automatic test_invalid_op();
    start = 1'b1;
    op = 2'b01;
    a = 32'd9;
    b = 32'd0;
    tick();
    start = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      start = 1'b1;
      op = (k == 0) ? 2'b10 : 2'b11;
      a = 32'd8;
      b = 32'd2;
      tick();
      start = 1'b0;
      total++;
      if ({busy, done, div_zero} !== 3'b001) begin
        bad++;
        $display("FAIL inv_flags: op %b got %b want 001",
                 op, {busy, done, div_zero});
      end
      tick();
      total++;
      if (hi !== 32'd9 || lo !== 32'hFFFF_FFFF || done !== 1'b0) begin
        bad++;
        $display("FAIL inv_hilo: op %b got %h_%h done %b want 9_ffffffff 0",
                 op, hi, lo, done);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_multu_max();
    test_divu();
    test_div_zero_back_to_back();
    test_stall();
    test_reset_mid_div();
    test_invalid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
